// File: rtl/regfile_wb_ctrl.sv
// Write-port controller for the integer register file: zero-init of x1..x31,
// round-robin ALU/LSU writeback arbitration and a busy scoreboard for issue hazards.
module regfile_wb_ctrl #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_wd,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_wd,
  output logic            lsu_ready,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_stall,
  output logic            rf_we,
  output logic [AW-1:0]   rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic            init_done
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);
  localparam logic          SRC_ALU  = 1'b0;
  localparam logic          SRC_LSU  = 1'b1;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic [NREG-1:0] r_busy;
  logic            r_rr_last;
  logic            r_we;
  logic [AW-1:0]   r_wa;
  logic [XLEN-1:0] r_wd;
  logic            r_init_done;

  logic            w_run;
  logic            w_alu_gnt;
  logic            w_lsu_gnt;
  logic            w_wb_gnt;
  logic            w_wb_we;
  logic [AW-1:0]   w_wb_rd;
  logic [XLEN-1:0] w_wb_wd;
  logic            w_stall;
  logic            w_iss_acc;
  logic [NREG-1:0] w_busy_nxt;

  // Arbitration, hazard detection and next scoreboard value.
  always_comb begin
    w_run      = (r_state == S_RUN);
    w_alu_gnt  = 1'b0;
    w_lsu_gnt  = 1'b0;
    w_wb_rd    = '0;
    w_wb_wd    = '0;
    w_stall    = 1'b1;
    w_busy_nxt = r_busy;

    if (w_run) begin
      // Tie goes to whichever source was not granted last.
      w_alu_gnt = alu_valid && (!lsu_valid || (r_rr_last == SRC_LSU));
      w_lsu_gnt = lsu_valid && (!alu_valid || (r_rr_last == SRC_ALU));
      w_stall   = r_busy[iss_rs1] | r_busy[iss_rs2] | r_busy[iss_rd];
    end

    if (w_alu_gnt) begin
      w_wb_rd = alu_rd;
      w_wb_wd = alu_wd;
    end else if (w_lsu_gnt) begin
      w_wb_rd = lsu_rd;
      w_wb_wd = lsu_wd;
    end

    w_wb_gnt  = w_alu_gnt | w_lsu_gnt;
    w_wb_we   = w_wb_gnt && (w_wb_rd != '0);
    w_iss_acc = iss_valid && !w_stall;

    // Clear first so a same-cycle issue to the same register keeps it busy.
    if (w_wb_we) begin
      w_busy_nxt[w_wb_rd] = 1'b0;
    end
    if (w_iss_acc && (iss_rd != '0)) begin
      w_busy_nxt[iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // FSM, write-port output register, round-robin pointer and scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_cnt       <= AW'(1);
      r_busy      <= '0;
      r_rr_last   <= SRC_LSU;
      r_we        <= 1'b0;
      r_wa        <= '0;
      r_wd        <= '0;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_we <= 1'b1;
          r_wa <= r_cnt;
          r_wd <= '0;
          if (r_cnt == LAST_REG) begin
            r_state <= S_RUN;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        S_RUN: begin
          r_init_done <= 1'b1;
          r_we        <= w_wb_we;
          if (w_wb_we) begin
            r_wa <= w_wb_rd;
            r_wd <= w_wb_wd;
          end
          if (w_wb_gnt) begin
            r_rr_last <= w_lsu_gnt;
          end
          r_busy <= w_busy_nxt;
        end
      endcase
    end
  end

  assign alu_ready = w_alu_gnt;
  assign lsu_ready = w_lsu_gnt;
  assign iss_stall = w_stall;
  assign rf_we     = r_we;
  assign rf_wa     = r_wa;
  assign rf_wd     = r_wd;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios plus a randomized phase,
// checked against a behavioural model of init, arbitration and the scoreboard.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_wd = '0;
  logic        alu_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_wd = '0;
  logic        lsu_ready;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rs1 = '0;
  logic [4:0]  iss_rs2 = '0;
  logic [4:0]  iss_rd = '0;
  logic        iss_stall;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        init_done;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit        m_run;
  int        m_writes;
  bit [31:0] m_busy;
  bit        m_last_lsu;
  bit        m_we;
  bit [4:0]  m_wa;
  bit [31:0] m_wd;
  bit        m_done;
  bit        g_alu;
  bit        g_lsu;

  regfile_wb_ctrl #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd), .lsu_ready(lsu_ready),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_stall(iss_stall),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit busy_of(input bit [4:0] r);
    return (r == 5'd0) ? 1'b0 : m_busy[r];
  endfunction

  task automatic model_reset();
    m_run = 0; m_writes = 0; m_busy = '0; m_last_lsu = 1;
    m_we = 0; m_wa = '0; m_wd = '0; m_done = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'(m_we));
    chk({tag, ".rf_wa"}, 32'(rf_wa), 32'(m_wa));
    chk({tag, ".rf_wd"}, rf_wd, m_wd);
    chk({tag, ".init_done"}, 32'(init_done), 32'(m_done));
  endtask

  // One clock: check combinational outputs mid-cycle, advance model, check registers.
  task automatic step(input string tag);
    bit stall;
    @(negedge clk);
    if (!m_run) begin
      g_alu = 0; g_lsu = 0; stall = 1;
    end else begin
      g_alu = alu_valid && (!lsu_valid || m_last_lsu);
      g_lsu = lsu_valid && (!alu_valid || !m_last_lsu);
      stall = busy_of(iss_rs1) | busy_of(iss_rs2) | busy_of(iss_rd);
    end
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(g_alu));
    chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(g_lsu));
    chk({tag, ".iss_stall"}, 32'(iss_stall), 32'(stall));
    @(posedge clk);
    if (!m_run) begin
      m_writes++;
      m_we = 1; m_wa = 5'(m_writes); m_wd = '0;
      if (m_writes == 31) m_run = 1;
    end else begin
      m_done = 1;
      m_we = 0;
      if (g_alu || g_lsu) begin
        bit [4:0]  rd;
        bit [31:0] wd;
        rd = g_alu ? alu_rd : lsu_rd;
        wd = g_alu ? alu_wd : lsu_wd;
        m_last_lsu = g_lsu;
        if (rd != 0) begin
          m_we = 1; m_wa = rd; m_wd = wd;
          m_busy[rd] = 0;
        end
      end
      if (iss_valid && !stall && iss_rd != 0) m_busy[iss_rd] = 1;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; iss_valid = 0;
    alu_rd = 0; lsu_rd = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
  endtask

  initial begin
    model_reset();
    // Reset values
    #2;
    check_regs("reset");
    chk("reset.iss_stall", 32'(iss_stall), 32'd1);

    // Init: valids and issue held high must be ignored
    alu_valid = 1; alu_rd = 5'd2; alu_wd = 32'hAAAA;
    lsu_valid = 1; lsu_rd = 5'd3; lsu_wd = 32'hBBBB;
    iss_valid = 1; iss_rd = 5'd4;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 32; i++) step("init");
    idle_inputs();

    // Single ALU request
    alu_valid = 1; alu_rd = 5'd5; alu_wd = 32'h1234;
    step("alu_alone");
    idle_inputs();
    step("idle_hold");

    // LSU alone, then continuous contention alternates starting with ALU
    lsu_valid = 1; lsu_rd = 5'd8; lsu_wd = 32'h88;
    step("lsu_alone");
    alu_valid = 1; alu_rd = 5'd3; alu_wd = 32'h33;
    lsu_valid = 1; lsu_rd = 5'd4; lsu_wd = 32'h44;
    for (int i = 0; i < 4; i++) step("rr");
    idle_inputs();

    // RAW on x7 held until the LSU writeback clears it
    iss_valid = 1; iss_rd = 5'd7;
    step("iss_rd7");
    iss_rd = 5'd0; iss_rs1 = 5'd7;
    step("raw7_a");
    step("raw7_b");
    lsu_valid = 1; lsu_rd = 5'd7; lsu_wd = $urandom;
    step("raw7_wb");
    lsu_valid = 0;
    step("raw7_clear");
    idle_inputs();

    // Same-cycle set and clear of x9: set wins
    iss_valid = 1; iss_rd = 5'd9;
    alu_valid = 1; alu_rd = 5'd9; alu_wd = 32'h99;
    step("set_clr9");
    idle_inputs();
    iss_valid = 1; iss_rs2 = 5'd9;
    step("raw9");
    lsu_valid = 1; lsu_rd = 5'd9; lsu_wd = 32'h999;
    step("wb9");
    idle_inputs();
    step("settle");

    // Randomized traffic; requesters hold their request until accepted
    for (int i = 0; i < 300; i++) begin
      if (!alu_valid || g_alu) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd = 5'($urandom_range(0, 7)); alu_wd = $urandom;
      end
      if (!lsu_valid || g_lsu) begin
        lsu_valid = ($urandom_range(0, 2) != 0);
        lsu_rd = 5'($urandom_range(0, 7)); lsu_wd = $urandom;
      end
      iss_valid = $urandom_range(0, 1);
      iss_rs1 = 5'($urandom_range(0, 7));
      iss_rs2 = 5'($urandom_range(0, 7));
      iss_rd  = 5'($urandom_range(0, 7));
      step("rand");
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) step("drain");

    // rd=0 writeback consumes the grant but does not write
    alu_valid = 1; alu_rd = 5'd0; alu_wd = 32'hDEAD;
    step("alu_rd0");
    idle_inputs();

    // Mark x6 busy, then reset mid-cycle
    iss_valid = 1; iss_rd = 5'd6;
    step("iss_rd6");
    idle_inputs();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_regs("midreset");
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 32; i++) step("reinit");
    iss_valid = 1; iss_rs1 = 5'd6; iss_rd = 5'd6;
    step("x6_free");
    idle_inputs();
    step("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Controller in front of the integer register file's single write port.
- After reset it runs an init sequence that writes zero to x1..x31.
- It then arbitrates round-robin between two writeback requesters: the ALU and the load/store unit.
- It keeps a per-register busy scoreboard and stalls issue on RAW/WAW hazards against pending writes.

Parameters:
- XLEN, 32, data width of writeback data and regfile write data
- NREG, 32, number of architectural registers (x0 hardwired zero)
- AW, 5, register address width (log2 NREG)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- alu_valid  input  1  ALU writeback request
- alu_rd  input  AW  ALU destination register
- alu_wd  input  XLEN  ALU writeback data
- alu_ready  output  1  ALU request accepted this cycle
- lsu_valid  input  1  LSU writeback request
- lsu_rd  input  AW  LSU destination register
- lsu_wd  input  XLEN  LSU writeback data
- lsu_ready  output  1  LSU request accepted this cycle
- iss_valid  input  1  decode issuing an instruction
- iss_rs1  input  AW  source register 1
- iss_rs2  input  AW  source register 2
- iss_rd  input  AW  destination register
- iss_stall  output  1  issue blocked (hazard or init)
- rf_we  output  1  regfile write enable (registered)
- rf_wa  output  AW  regfile write address (registered)
- rf_wd  output  XLEN  regfile write data (registered)
- init_done  output  1  high once init sequence has completed

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=INIT, init counter=1, busy=0, rr_last=LSU (so ALU wins the first tie).
  - Outputs: rf_we=0, rf_wa=0, rf_wd=0, init_done=0.
  - Assertion mid-operation discards any pending writes and scoreboard state immediately.
- FSM states INIT and RUN:
  - INIT: each cycle registers rf_we=1, rf_wa=cnt, rf_wd=0, then cnt++.
  - When cnt=31 is issued, go to RUN next cycle. Writes land on cycles 1..31 after reset release.
  - init_done rises in the same cycle rf_we drops after the x31 write.
- In INIT: alu_ready=lsu_ready=0, iss_stall=1 regardless of inputs.
- RUN arbitration:
  - alu_ready/lsu_ready are combinational from valids and rr_last.
  - Only one is high per cycle.
  - If both valid, grant the one not equal to rr_last; rr_last updates to the granted source on every grant.
  - A single valid requester is always granted.
- Write latency: a granted request produces rf_we/rf_wa/rf_wd on the next clock edge, exactly one cycle.
  - With no grant, rf_we=0; rf_wa/rf_wd hold their previous values.
- rd=0 writeback: request is granted and consumes arbitration (ready=1, rr_last updates), but rf_we stays 0 and no scoreboard change occurs.
- Scoreboard busy[31:1], busy[0] constant 0:
  - Set: iss_valid && !iss_stall && iss_rd!=0 sets busy[iss_rd] at the clock edge.
  - Clear: a granted writeback with rd!=0 clears busy[rd] at the clock edge.
  - Same register set and cleared in the same cycle: set wins.
- iss_stall (RUN) is combinational: busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd].
  - x0 never stalls.
  - Stall reflects registered busy only; a clear takes effect the cycle after the grant.
- Requesters must hold valid/rd/wd stable until ready. The block does not buffer, so there is no full/empty condition beyond the one-cycle output register.

Test Plan:
- Release rst_n -> rf_we high for 31 consecutive cycles, rf_wa=1..31, rf_wd=0; init_done=1 on cycle 32; iss_stall=1 throughout INIT; both readys 0 even with valids high.
- RUN, alu_valid=1 rd=5 wd=0x1234 alone -> alu_ready=1 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0x00001234.
- Both valid continuously (alu rd=3, lsu rd=4) -> grants alternate ALU, LSU, ALU, LSU starting with ALU; rf_wa sequence 3,4,3,4.
- Issue rd=7 (no stall), then issue rs1=7 -> iss_stall=1 until the cycle after an lsu writeback to rd=7 is granted, then 0.
- In the same cycle, issue rd=9 and grant a writeback to rd=9 with busy[9] set -> busy[9] remains 1; a following issue with rs2=9 stalls.
- ALU writeback rd=0 -> alu_ready=1, next cycle rf_we=0; drop rst_n mid-RUN with busy[6]=1 -> outputs zero immediately, FSM restarts INIT, busy[6]=0 after init.
